// File: rtl/core_memory.sv
// ---------------------------------------------------------------------------
// core_memory : memory-access stage between execute and writeback.
//
// Accepts one instruction per m_valid/m_ready handshake. Loads and stores are
// performed on the data-memory bus with a req/ack handshake; everything else
// goes straight to the single output register facing writeback.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   m_*                   instruction bundle from execute (m_ready is output)
//   w_*                   result bundle to writeback (w_ready is input)
//   dmem_req/we/addr/be/wdata   bus request, held until dmem_ack
//   dmem_ack/rdata        bus completion, read data valid with ack
//
// Build option
//   CORE_MEM_MISALIGN_TRAP_EN  defined: misaligned half/word accesses issue no
//                              bus request and retire next cycle with w_trap=1,
//                              w_reg_wen=0. Undefined: w_trap tied to 0 and
//                              misaligned offsets are truncated.
//
// FSM states
//   state | meaning
//   IDLE  | ready for a new instruction when the output register is free
//   BUS   | request outstanding on the data-memory bus
//   DONE  | result registered (held by the output register / w_valid; the
//         | FSM returns straight to IDLE so this encoding is never parked in)
// ---------------------------------------------------------------------------
module core_memory (
    input  logic        clk,
    input  logic        rst,

    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_imm,
    input  logic [31:0] m_rs2,
    input  logic [4:0]  m_rd,
    input  logic        m_reg_wen,
    input  logic [1:0]  m_reg_wsel,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_alu_sum,
    input  logic [2:0]  m_mem_type,
    input  logic        m_mem_ren,
    input  logic        m_mem_wen,
    output logic        m_ready,

    output logic        w_valid,
    output logic [4:0]  w_rd,
    output logic        w_reg_wen,
    output logic [31:0] w_wdata,
    output logic        w_trap,
    input  logic        w_ready,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;

    // Fields kept for the writeback value while the bus transaction runs
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic [31:0] alu_out_q;
    logic [4:0]  rd_q;
    logic        reg_wen_q;
    logic [1:0]  wsel_q;
    logic [2:0]  mem_type_q;
    logic [1:0]  off_q;

    logic        out_free;
    logic        accept;
    logic        is_access;
    logic        is_byte;
    logic        is_half;
    logic [1:0]  addr_off;
    logic [1:0]  acc_off;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic        mis_trap;

    // Size is encoded in funct3[1:0]: 00 byte, 01 half, 10/11 word.
    assign is_byte  = (m_mem_type[1:0] == 2'b00);
    assign is_half  = (m_mem_type[1:0] == 2'b01);
    assign addr_off = m_alu_sum[1:0];

    // Effective lane offset: half ignores bit 0, word always starts at lane 0.
    assign acc_off  = is_byte ? addr_off :
                      is_half ? {addr_off[1], 1'b0} : 2'b00;

    assign acc_be   = is_byte ? (4'b0001 << acc_off) :
                      is_half ? (4'b0011 << acc_off) : 4'b1111;

    assign acc_wdata = is_byte ? {4{m_rs2[7:0]}} :
                       is_half ? {2{m_rs2[15:0]}} : m_rs2;

    assign out_free  = ~w_valid | w_ready;
    assign m_ready   = (state == IDLE) & out_free;
    assign accept    = m_valid & m_ready;
    assign is_access = m_mem_ren | m_mem_wen;

`ifdef CORE_MEM_MISALIGN_TRAP_EN
    logic trap_q;
    assign mis_trap = is_access &
                      ((is_half & addr_off[0]) |
                       (~is_byte & ~is_half & (addr_off != 2'b00)));
    assign w_trap   = trap_q;
`else
    assign mis_trap = 1'b0;
    assign w_trap   = 1'b0;
`endif

    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  mem_type);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (mem_type)
            3'b000:  res = {{24{sh[7]}},  sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'd0, sh[7:0]};
            3'b101:  res = {16'd0, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] wb_select(input logic [1:0]  wsel,
                                              input logic [31:0] alu_out,
                                              input logic [31:0] load_data,
                                              input logic [31:0] pc,
                                              input logic [31:0] imm);
        logic [31:0] res;
        case (wsel)
            2'b00:   res = alu_out;
            2'b01:   res = load_data;
            2'b10:   res = pc + 32'd4;
            default: res = imm;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            w_valid    <= 1'b0;
            w_rd       <= 5'd0;
            w_reg_wen  <= 1'b0;
            w_wdata    <= 32'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            pc_q       <= 32'd0;
            imm_q      <= 32'd0;
            alu_out_q  <= 32'd0;
            rd_q       <= 5'd0;
            reg_wen_q  <= 1'b0;
            wsel_q     <= 2'd0;
            mem_type_q <= 3'd0;
            off_q      <= 2'd0;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            // Writeback took the result; a new write below overrides this.
            if (w_valid && w_ready) begin
                w_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_access && !mis_trap) begin
                            pc_q       <= m_pc;
                            imm_q      <= m_imm;
                            alu_out_q  <= m_alu_out;
                            rd_q       <= m_rd;
                            reg_wen_q  <= m_reg_wen;
                            wsel_q     <= m_reg_wsel;
                            mem_type_q <= m_mem_type;
                            off_q      <= acc_off;
                            dmem_req   <= 1'b1;
                            dmem_we    <= m_mem_wen;
                            dmem_addr  <= {m_alu_sum[31:2], 2'b00};
                            dmem_be    <= m_mem_wen ? acc_be : 4'b0000;
                            dmem_wdata <= acc_wdata;
                            state      <= BUS;
                        end else begin
                            w_valid   <= 1'b1;
                            w_rd      <= m_rd;
                            w_reg_wen <= m_reg_wen & ~mis_trap;
                            w_wdata   <= wb_select(m_reg_wsel, m_alu_out, 32'd0,
                                                   m_pc, m_imm);
`ifdef CORE_MEM_MISALIGN_TRAP_EN
                            trap_q    <= mis_trap;
`endif
                        end
                    end
                end

                BUS: begin
                    // The output register is always free here: accept required
                    // it to drain, and nothing else can fill it meanwhile.
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        w_valid   <= 1'b1;
                        w_rd      <= rd_q;
                        w_reg_wen <= reg_wen_q;
                        w_wdata   <= wb_select(wsel_q, alu_out_q,
                                               load_extend(dmem_rdata, off_q,
                                                           mem_type_q),
                                               pc_q, imm_q);
`ifdef CORE_MEM_MISALIGN_TRAP_EN
                        trap_q    <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_memory.sv
module tb_core_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic [31:0] m_pc, m_imm, m_rs2, m_alu_out, m_alu_sum;
    logic [4:0]  m_rd;
    logic        m_reg_wen;
    logic [1:0]  m_reg_wsel;
    logic [2:0]  m_mem_type;
    logic        m_mem_ren, m_mem_wen;
    logic        m_ready;
    logic        w_valid;
    logic [4:0]  w_rd;
    logic        w_reg_wen;
    logic [31:0] w_wdata;
    logic        w_trap;
    logic        w_ready;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] last_wdata;
    logic [3:0]  last_be;
    logic [31:0] last_sdata;

    always #5 clk = ~clk;

    core_memory dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_pc(m_pc), .m_imm(m_imm), .m_rs2(m_rs2),
        .m_rd(m_rd), .m_reg_wen(m_reg_wen), .m_reg_wsel(m_reg_wsel),
        .m_alu_out(m_alu_out), .m_alu_sum(m_alu_sum), .m_mem_type(m_mem_type),
        .m_mem_ren(m_mem_ren), .m_mem_wen(m_mem_wen), .m_ready(m_ready),
        .w_valid(w_valid), .w_rd(w_rd), .w_reg_wen(w_reg_wen),
        .w_wdata(w_wdata), .w_trap(w_trap), .w_ready(w_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic [31:0] pc, imm, rs2, alu_out, alu_sum;
        logic [4:0]  rd;
        logic        reg_wen;
        logic [1:0]  wsel;
        logic [2:0]  mt;
        logic        ren, wen;
    } instr_t;

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] wdata;
    } res_t;

    res_t expq[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] mt);
        case (mt)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int eff_off(input int a, input logic [2:0] mt);
        int sz = size_of(mt);
        if (sz == 1) return a;
        if (sz == 2) return a - (a % 2);
        return 0;
    endfunction

    function automatic bit misaligned(input int a, input logic [2:0] mt);
        int sz = size_of(mt);
        return (sz == 2 && (a % 2) == 1) || (sz == 4 && a != 0);
    endfunction

    function automatic logic [3:0] exp_be(input int a, input logic [2:0] mt);
        logic [3:0] b = 4'd0;
        int off = eff_off(a, mt);
        int sz  = size_of(mt);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sz) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] exp_sdata(input logic [31:0] rs2, input logic [2:0] mt);
        logic [31:0] v = 32'd0;
        int sz = size_of(mt);
        for (int i = 0; i < 4; i++)
            v = v | (((rs2 >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return v;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input int a,
                                             input logic [2:0] mt);
        logic [31:0] v = 32'd0;
        int sz  = size_of(mt);
        int off = eff_off(a, mt);
        for (int i = 0; i < sz; i++)
            v = v + (((rdata >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (sz < 4 && mt[2] == 1'b0 && v >= (32'd1 << (8 * sz - 1)))
            v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input instr_t t, input logic [31:0] ld);
        case (t.wsel)
            2'd0:    return t.alu_out;
            2'd1:    return ld;
            2'd2:    return t.pc + 32'd4;
            default: return t.imm;
        endcase
    endfunction

    // kind: 0 non-memory, 1 load, 2 store
    function automatic instr_t rand_instr(input int kind);
        instr_t t;
        int w;
        t.pc      = $urandom & 32'hFFFF_FFFC;
        t.imm     = $urandom;
        t.rs2     = $urandom;
        t.alu_out = $urandom;
        t.alu_sum = $urandom;
        t.rd      = 5'($urandom_range(0, 31));
        t.mt      = 3'($urandom_range(0, 7));
        w         = int'($urandom_range(0, 2));
        t.wsel    = (w == 0) ? 2'd0 : (w == 1) ? 2'd2 : 2'd3;
        t.reg_wen = 1'($urandom_range(0, 1));
        t.ren     = 1'b0;
        t.wen     = 1'b0;
        if (kind == 1) begin
            t.ren = 1'b1; t.reg_wen = 1'b1; t.wsel = 2'd1;
        end else if (kind == 2) begin
            t.wen = 1'b1; t.reg_wen = 1'b0;
        end
        return t;
    endfunction

    task automatic drive(input instr_t t);
        m_pc = t.pc; m_imm = t.imm; m_rs2 = t.rs2; m_alu_out = t.alu_out;
        m_alu_sum = t.alu_sum; m_rd = t.rd; m_reg_wen = t.reg_wen;
        m_reg_wsel = t.wsel; m_mem_type = t.mt; m_mem_ren = t.ren; m_mem_wen = t.wen;
    endtask

    // Starts and ends at a falling edge with the stage idle and empty.
    task automatic run_one(input instr_t t, input int waits, input logic [31:0] rdata,
                           input string tag);
        int a;
        bit acc, trp;
        logic [31:0] ld;
        a   = int'(t.alu_sum[1:0]);
        acc = t.ren || t.wen;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
        trp = acc && misaligned(a, t.mt);
`else
        trp = 1'b0;
`endif
        drive(t);
        m_valid = 1'b1;
        w_ready = 1'b1;
        #1;
        check({tag, ".m_ready_idle"}, 32'(m_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0;
        ld = 32'd0;
        if (acc && !trp) begin
            check({tag, ".req"},  32'(dmem_req), 32'd1);
            check({tag, ".addr"}, dmem_addr, t.alu_sum & 32'hFFFF_FFFC);
            check({tag, ".we"},   32'(dmem_we), 32'(t.wen));
            check({tag, ".be"},   32'(dmem_be), t.wen ? 32'(exp_be(a, t.mt)) : 32'd0);
            if (t.wen) check({tag, ".sdata"}, dmem_wdata, exp_sdata(t.rs2, t.mt));
            last_be    = dmem_be;
            last_sdata = dmem_wdata;
            check({tag, ".m_ready_bus"}, 32'(m_ready), 32'd0);
            for (int i = 0; i < waits; i++) begin
                @(negedge clk);
                check({tag, ".req_hold"}, 32'(dmem_req), 32'd1);
                check({tag, ".m_ready_wait"}, 32'(m_ready), 32'd0);
                check({tag, ".w_valid_wait"}, 32'(w_valid), 32'd0);
            end
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            ld = exp_load(rdata, a, t.mt);
        end
        check({tag, ".req_after"}, 32'(dmem_req), 32'd0);
        check({tag, ".w_valid"},   32'(w_valid), 32'd1);
        check({tag, ".w_rd"},      32'(w_rd), 32'(t.rd));
        check({tag, ".w_reg_wen"}, 32'(w_reg_wen), trp ? 32'd0 : 32'(t.reg_wen));
        check({tag, ".w_trap"},    32'(w_trap), 32'(trp));
        if (!trp) check({tag, ".w_wdata"}, w_wdata, exp_wdata(t, ld));
        last_wdata = w_wdata;
        check({tag, ".m_ready_out"}, 32'(m_ready), 32'd1);
        @(negedge clk);
        check({tag, ".w_valid_drain"}, 32'(w_valid), 32'd0);
    endtask

    initial begin
        instr_t t;
        instr_t cur;
        res_t   r;
        int     sent, got, cyc;
        bit     acc_now;

        rst = 1'b1; m_valid = 1'b0; w_ready = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        t = rand_instr(0);
        drive(t);
        repeat (3) @(negedge clk);

        // reset state
        check("rst.w_valid",   32'(w_valid),   32'd0);
        check("rst.w_trap",    32'(w_trap),    32'd0);
        check("rst.w_reg_wen", 32'(w_reg_wen), 32'd0);
        check("rst.w_rd",      32'(w_rd),      32'd0);
        check("rst.w_wdata",   w_wdata,        32'd0);
        check("rst.req",       32'(dmem_req),  32'd0);
        check("rst.we",        32'(dmem_we),   32'd0);
        check("rst.be",        32'(dmem_be),   32'd0);
        rst = 1'b0;
        #1;
        check("rst.m_ready", 32'(m_ready), 32'd1);
        @(negedge clk);

        // ALU op
        t = rand_instr(0);
        t.alu_out = 32'h1234; t.wsel = 2'd0; t.rd = 5'd5; t.reg_wen = 1'b1;
        run_one(t, 0, 32'd0, "alu");
        check("alu.const", last_wdata, 32'h0000_1234);

        // signed / unsigned byte load at 0x103, three wait cycles
        t = rand_instr(1);
        t.alu_sum = 32'h103; t.mt = 3'b000;
        run_one(t, 3, 32'h80FF_FFFF, "lb");
        check("lb.const", last_wdata, 32'hFFFF_FF80);
        check("lb.be_const", 32'(last_be), 32'd0);
        t.mt = 3'b100;
        run_one(t, 3, 32'h80FF_FFFF, "lbu");
        check("lbu.const", last_wdata, 32'h0000_0080);

        // half store
        t = rand_instr(2);
        t.alu_sum = 32'h202; t.mt = 3'b001; t.rs2 = 32'hDEAD_BEEF;
        run_one(t, 2, $urandom, "sh");
        check("sh.be_const", 32'(last_be), 32'hC);
        check("sh.sdata_const", last_sdata, 32'hBEEF_BEEF);

        // misaligned word load at 0x101 (trap or truncated depending on build)
        t = rand_instr(1);
        t.alu_sum = 32'h101; t.mt = 3'b010;
        run_one(t, 1, 32'hA1B2_C3D4, "lw_mis");

        // stray ack while idle is ignored
        dmem_ack = 1'b1; dmem_rdata = $urandom;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("idle_ack.w_valid", 32'(w_valid), 32'd0);
        check("idle_ack.req",     32'(dmem_req), 32'd0);

        // reset while request outstanding, then a late ack
        t = rand_instr(1);
        t.mt = 3'b010; t.alu_sum = t.alu_sum & 32'hFFFF_FFFC;
        drive(t); m_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0;
        check("rstbus.req_before", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstbus.req",     32'(dmem_req), 32'd0);
        check("rstbus.w_valid", 32'(w_valid),  32'd0);
        check("rstbus.m_ready", 32'(m_ready),  32'd1);
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = $urandom;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("rstbus.late_ack_w_valid", 32'(w_valid),  32'd0);
        check("rstbus.late_ack_req",     32'(dmem_req), 32'd0);

        // back-to-back stream with backpressure (w_ready low cycles 5..8)
        sent = 0; got = 0; cyc = 0;
        cur = rand_instr(0);
        while ((sent < 30 || expq.size() > 0) && cyc < 500) begin
            drive(cur);
            m_valid = (sent < 30);
            w_ready = (cyc >= 5 && cyc < 9) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            check("stream.m_ready", 32'(m_ready), 32'((expq.size() == 0) || w_ready));
            check("stream.w_valid", 32'(w_valid), 32'(expq.size() != 0));
            if (expq.size() != 0) begin
                check("stream.w_rd",      32'(w_rd),      32'(expq[0].rd));
                check("stream.w_reg_wen", 32'(w_reg_wen), 32'(expq[0].wen));
                check("stream.w_wdata",   w_wdata,        expq[0].wdata);
            end
            acc_now = m_valid && ((expq.size() == 0) || w_ready);
            @(posedge clk);
            if (w_ready && expq.size() != 0) begin
                void'(expq.pop_front());
                got++;
            end
            if (acc_now) begin
                r.rd = cur.rd; r.wen = cur.reg_wen; r.wdata = exp_wdata(cur, 32'd0);
                expq.push_back(r);
                sent++;
                cur = rand_instr(0);
            end
            @(negedge clk);
            cyc++;
        end
        m_valid = 1'b0;
        w_ready = 1'b1;
        check("stream.delivered", 32'(got), 32'd30);
        @(negedge clk);

        // randomized mix of loads, stores and ALU ops
        for (int k = 0; k < 40; k++) begin
            t = rand_instr(int'($urandom_range(0, 2)));
            run_one(t, int'($urandom_range(0, 3)), $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
